// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
// Segment encoding is active-low {g,f,e,d,c,b,a}; used only when KEYPAD_SEG7_EN is defined.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } kp_state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Codes above 0xF have no hex glyph and show a dash instead.
    function automatic logic [6:0] hex_to_seg7(input logic [7:0] code);
        logic [6:0] seg;
        seg = SEG_DASH;
        if (code <= 8'd15) begin
            case (code[3:0])
                4'h0: seg = 7'b1000000;
                4'h1: seg = 7'b1111001;
                4'h2: seg = 7'b0100100;
                4'h3: seg = 7'b0110000;
                4'h4: seg = 7'b0011001;
                4'h5: seg = 7'b0010010;
                4'h6: seg = 7'b0000010;
                4'h7: seg = 7'b1111000;
                4'h8: seg = 7'b0000000;
                4'h9: seg = 7'b0010000;
                4'hA: seg = 7'b0001000;
                4'hB: seg = 7'b0000011;
                4'hC: seg = 7'b1000110;
                4'hD: seg = 7'b0100001;
                4'hE: seg = 7'b0000110;
                default: seg = 7'b0001110;
            endcase
        end
        return seg;
    endfunction

endpackage

// File: rtl/keypad_debounce_cnt.sv
// Tick-qualified stability counter; term_o flags that the next counted tick
// completes DEBOUNCE_TICKS consecutive stable ticks.
module keypad_debounce_cnt #(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic term_o
);

    localparam int CW     = (DEBOUNCE_TICKS < 2) ? 1 : $clog2(DEBOUNCE_TICKS);
    localparam int TERM_I = (DEBOUNCE_TICKS >= 2) ? DEBOUNCE_TICKS - 2 : 0;
    localparam logic [CW-1:0] TERM = CW'(TERM_I);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (tick_i) begin
            if (clr_i)      cnt_d = '0;
            else if (inc_i) cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    // The capture tick counts as the first stable one, so compare pre-increment.
    assign term_o = (cnt_q >= TERM);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Parametrised matrix-keypad scanner: column drive, debounce FSM and key handshake.
// Optional 7-segment readout of the last loaded code when KEYPAD_SEG7_EN is defined.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 4,
    localparam int CODE_W        = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROWS-1:0]   row_signal,
    output logic [COLS-1:0]   col_signal,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_held,
    output logic              key_lost
`ifdef KEYPAD_SEG7_EN
    ,
    output logic [6:0]        seg_data
`endif
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    logic [ROWS-1:0]   row_s1_q, row_s2_q;
    logic [DIV_W-1:0]  div_q, div_d;
    kp_state_e         state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d, col_next;
    logic [ROW_W-1:0]  row_sel_q, row_sel_d, low_idx;
    logic [CODE_W-1:0] code_q, code_d, new_code;
    logic              valid_q, valid_d, held_q, held_d, lost_q, lost_d;
    logic              tick, low_any, row_low, load;
    logic              cnt_clr, cnt_inc, cnt_term, accept, release_acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_s1_q <= '1;
            row_s2_q <= '1;
        end else begin
            row_s1_q <= row_signal;
            row_s2_q <= row_s1_q;
        end
    end

    assign tick  = (div_q == DIV_W'(SCAN_DIV - 1));
    assign div_d = tick ? '0 : div_q + 1'b1;

    assign col_next = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + 1'b1;
    assign low_any  = |(~row_s2_q);
    assign row_low  = ~row_s2_q[row_sel_q];
    assign new_code = CODE_W'(int'(row_sel_q) * COLS + int'(col_q));

    // Descending scan so the lowest-index low row wins.
    always_comb begin
        low_idx = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!row_s2_q[r]) low_idx = ROW_W'(r);
        end
    end

    keypad_debounce_cnt #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .tick_i (tick),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .term_o (cnt_term)
    );

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_sel_d   = row_sel_q;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        accept      = 1'b0;
        release_acc = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (low_any) begin
                        row_sel_d = low_idx;
                        cnt_clr   = 1'b1;
                        state_d   = DEBOUNCE;
                    end else begin
                        col_d = col_next;
                    end
                end
                DEBOUNCE: begin
                    if (row_low) begin
                        cnt_inc = 1'b1;
                        if (cnt_term) begin
                            accept  = 1'b1;
                            state_d = HELD;
                        end
                    end else begin
                        state_d = SCAN;
                        col_d   = col_next;
                    end
                end
                HELD: begin
                    if (!row_low) begin
                        cnt_clr = 1'b1;
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (!row_low) begin
                        cnt_inc = 1'b1;
                        if (cnt_term) begin
                            release_acc = 1'b1;
                            state_d     = SCAN;
                            col_d       = col_next;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    // A press arriving while the previous code is still undelivered is dropped.
    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        held_d  = held_q;
        lost_d  = 1'b0;
        load    = 1'b0;
        if (accept) begin
            held_d = 1'b1;
            if (!valid_q || key_ready) begin
                load    = 1'b1;
                code_d  = new_code;
                valid_d = 1'b1;
            end else begin
                lost_d = 1'b1;
            end
        end else if (valid_q && key_ready) begin
            valid_d = 1'b0;
        end
        if (release_acc) held_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q     <= '0;
            state_q   <= SCAN;
            col_q     <= '0;
            row_sel_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            held_q    <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            state_q   <= state_d;
            col_q     <= col_d;
            row_sel_q <= row_sel_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            held_q    <= held_d;
            lost_q    <= lost_d;
        end
    end

    assign col_signal = ~(COLS'(1) << col_q);
    assign key_code   = code_q;
    assign key_valid  = valid_q;
    assign key_held   = held_q;
    assign key_lost   = lost_q;

`ifdef KEYPAD_SEG7_EN
    logic [6:0] seg_q, seg_d;

    assign seg_d = load ? hex_to_seg7(8'(new_code)) : seg_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) seg_q <= SEG_BLANK;
        else      seg_q <= seg_d;
    end

    assign seg_data = seg_q;
`endif

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a physical keypad model plus a queue of expected key codes.
module tb_keypad_scan_ctrl;

    logic       clk, rst, key_ready;
    logic [3:0] row_signal, col_signal, key_code;
    logic       key_valid, key_held, key_lost;
`ifdef KEYPAD_SEG7_EN
    logic [6:0] seg_data;
`endif

    keypad_scan_ctrl #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_TICKS(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .row_signal (row_signal),
        .col_signal (col_signal),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_held   (key_held),
        .key_lost   (key_lost)
`ifdef KEYPAD_SEG7_EN
        ,
        .seg_data   (seg_data)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Keypad: a closed switch at (r,c) pulls row r low while column c is driven low.
    logic [3:0][3:0] pressed;
    always_comb begin
        row_signal = '1;
        for (int r = 0; r < 4; r++) row_signal[r] = ~|(pressed[r] & ~col_signal);
    end

    int checks = 0;
    int failures = 0;
    int events = 0;
    int lost_cnt = 0;
    bit rand_ready = 0;
    int exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock per iteration; inputs are final at the snapshot, so it shows what the posedge sees.
    task automatic cyc(input int n);
        logic       sv, sr;
        logic [3:0] sc;
        int         e;
        repeat (n) begin
            sv = key_valid;
            sr = key_ready;
            sc = key_code;
            @(negedge clk);
            if (sv === 1'b1 && sr === 1'b1) begin
                events++;
                if (exp_q.size() == 0) chk("spurious_key_valid", 32'(sv), 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("key_code", 32'(sc), 32'(e));
                end
            end else if (sv === 1'b1 && sr === 1'b0 && rst === 1'b1) begin
                chk("pending_valid", 32'(key_valid), 32'd1);
                chk("pending_code", 32'(key_code), 32'(sc));
            end
            if (key_lost === 1'b1) lost_cnt++;
            if (rand_ready) key_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_col(input logic [3:0] tgt);
        logic [3:0] prev;
        int n = 0;
        do begin
            prev = col_signal;
            cyc(1);
            n++;
        end while (!(col_signal == tgt && prev != tgt) && n < 64);
        if (!(col_signal == tgt && prev != tgt)) chk("wait_col_timeout", 32'(n), 32'd0);
    endtask

    task automatic wait_change(output int gap);
        logic [3:0] prev;
        prev = col_signal;
        gap = 0;
        do begin
            cyc(1);
            gap++;
        end while (col_signal == prev && gap < 64);
        if (col_signal == prev) chk("col_change_timeout", 32'(gap), 32'd0);
    endtask

    logic [3:0] exp_cols [4];
    int gap, ev0, lost0, k;
    bit frozen;

    initial begin
        exp_cols = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        rst = 1'b0; key_ready = 1'b1; pressed = '0;
        cyc(3);
        chk("rst_col", 32'(col_signal), 32'b1110);
        chk("rst_code", 32'(key_code), 32'd0);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_held", 32'(key_held), 32'd0);
        chk("rst_lost", 32'(key_lost), 32'd0);
`ifdef KEYPAD_SEG7_EN
        chk("rst_seg", 32'(seg_data), 32'b1111111);
`endif
        rst = 1'b1;

        // Idle scan: one column step every SCAN_DIV clocks.
        for (int i = 0; i < 4; i++) begin
            wait_change(gap);
            chk("scan_col", 32'(col_signal), 32'(exp_cols[i]));
            chk("scan_gap", 32'(gap), 32'd4);
        end
        chk("idle_valid", 32'(key_valid), 32'd0);

        // Clean press of key 6 (row 1, col 2).
        ev0 = events;
        wait_col(4'b1011);
        pressed[1][2] = 1'b1;
        exp_q.push_back(6);
        frozen = 1;
        repeat (24) begin
            cyc(1);
            if (col_signal != 4'b1011) frozen = 0;
        end
        chk("press_col_frozen", 32'(frozen), 32'd1);
        chk("press_held", 32'(key_held), 32'd1);
        pressed = '0;
        wait_change(gap);
        chk("release_col", 32'(col_signal), 32'b0111);
        chk("release_gap", 32'(gap >= 9 && gap <= 16), 32'd1);
        chk("release_held", 32'(key_held), 32'd0);
        chk("clean_events", 32'(events - ev0), 32'd1);

        // Two-tick press bounce: rejected, scan resumes at col 3.
        ev0 = events;
        wait_col(4'b1011);
        pressed[1][2] = 1'b1;
        cyc(9);
        pressed = '0;
        wait_change(gap);
        chk("bounce_col", 32'(col_signal), 32'b0111);
        chk("bounce_events", 32'(events - ev0), 32'd0);

        // One-tick release glitch on key 9: back to HELD, no second event.
        ev0 = events;
        wait_col(4'b1101);
        pressed[2][1] = 1'b1;
        exp_q.push_back(9);
        cyc(40);
        pressed = '0;
        cyc(4);
        pressed[2][1] = 1'b1;
        frozen = 1;
        repeat (20) begin
            cyc(1);
            if (col_signal != 4'b1101) frozen = 0;
        end
        chk("glitch_frozen", 32'(frozen), 32'd1);
        chk("glitch_held", 32'(key_held), 32'd1);
        pressed = '0;
        wait_change(gap);
        chk("glitch_col", 32'(col_signal), 32'b1011);
        chk("glitch_events", 32'(events - ev0), 32'd1);

        // Backpressure: key 5 pending, key 10 dropped.
        key_ready = 1'b0;
        lost0 = lost_cnt;
        wait_col(4'b1101);
        pressed[1][1] = 1'b1;
        exp_q.push_back(5);
        cyc(40);
        pressed = '0;
        cyc(24);
        chk("bp_valid", 32'(key_valid), 32'd1);
        chk("bp_code", 32'(key_code), 32'd5);
        wait_col(4'b1011);
        pressed[2][2] = 1'b1;
        cyc(40);
        pressed = '0;
        cyc(24);
        chk("bp_lost", 32'(lost_cnt - lost0), 32'd1);
        chk("bp_valid2", 32'(key_valid), 32'd1);
        chk("bp_code2", 32'(key_code), 32'd5);
        key_ready = 1'b1;
        cyc(1);
        chk("bp_drop", 32'(key_valid), 32'd0);

        // Rows 0 and 2 low on col 0: row 0 wins.
        wait_col(4'b1110);
        pressed[0][0] = 1'b1;
        pressed[2][0] = 1'b1;
        exp_q.push_back(0);
        cyc(40);
        pressed = '0;
        cyc(24);

        // Key 11 (row 2, col 3).
        wait_col(4'b0111);
        pressed[2][3] = 1'b1;
        exp_q.push_back(11);
        cyc(40);
`ifdef KEYPAD_SEG7_EN
        chk("seg_b", 32'(seg_data), 32'b0000011);
`endif
        pressed = '0;
        cyc(24);

        // Reset while HELD with key 15 pending.
        key_ready = 1'b0;
        wait_col(4'b0111);
        pressed[3][3] = 1'b1;
        cyc(40);
        chk("pre_rst_held", 32'(key_held), 32'd1);
        chk("pre_rst_code", 32'(key_code), 32'd15);
`ifdef KEYPAD_SEG7_EN
        chk("pre_rst_seg", 32'(seg_data), 32'b0001110);
`endif
        rst = 1'b0;
        #1;
        chk("mid_rst_col", 32'(col_signal), 32'b1110);
        chk("mid_rst_code", 32'(key_code), 32'd0);
        chk("mid_rst_valid", 32'(key_valid), 32'd0);
        chk("mid_rst_held", 32'(key_held), 32'd0);
        chk("mid_rst_lost", 32'(key_lost), 32'd0);
`ifdef KEYPAD_SEG7_EN
        chk("mid_rst_seg", 32'(seg_data), 32'b1111111);
`endif
        pressed = '0;
        cyc(2);
        rst = 1'b1;
        key_ready = 1'b1;

        // Random: short glitch on a random key, then a clean press; ready toggles randomly.
        rand_ready = 1;
        for (int i = 0; i < 12; i++) begin
            k = $urandom_range(0, 15);
            pressed[k / 4][k % 4] = 1'b1;
            cyc($urandom_range(1, 8));
            pressed = '0;
            cyc(12);
            k = $urandom_range(0, 15);
            pressed[k / 4][k % 4] = 1'b1;
            exp_q.push_back(k);
            cyc(40 + $urandom_range(0, 20));
            pressed = '0;
            cyc(24 + $urandom_range(0, 8));
        end
        rand_ready = 0;
        key_ready = 1'b1;
        cyc(8);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Parametrised matrix-keypad scanner, the successor to the fixed 4x4 scanner. It drives one column low at a time and samples the active-low rows through a synchroniser. Each key is debounced on both press and release. Each accepted press is delivered as a key code over a valid/ready handshake to downstream display or control logic.

Parameters:
ROWS, 4, number of row inputs (2..8)
COLS, 4, number of column outputs (2..8)
SCAN_DIV, 50000, clk cycles per scan tick (>=2)
DEBOUNCE_TICKS, 4, consecutive stable ticks needed to accept a press or a release (>=1)
CODE_W (localparam), $clog2(ROWS*COLS), key code width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
row_signal  in  ROWS  keypad rows, active-low, asynchronous to clk
col_signal  out  COLS  column drive, exactly one bit low while scanning
key_code  out  CODE_W  key code, equal to row_idx*COLS + col_idx
key_valid  out  1  key_code holds an undelivered press
key_ready  in  1  consumer accepts key_code
key_held  out  1  high from press acceptance until release acceptance
key_lost  out  1  one-cycle pulse when a press is dropped

Behaviour:
- Reset values: col_signal = all ones except bit0 = 0, key_code = 0, key_valid = 0, key_held = 0, key_lost = 0. The FSM is in SCAN and all counters are 0.
- Synchronisation: row_signal passes through a 2-flop synchroniser (reset value all ones). All decisions use the synchronised value.
- Prescaler: free-running counter over 0..SCAN_DIV-1. `tick` is high for one cycle when the count equals SCAN_DIV-1.
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE. The FSM acts only on tick cycles.
- SCAN on tick:
  - No row low: advance the column, wrapping COLS-1 to 0.
  - Any row low: capture cur_col and the lowest-index low row, clear the debounce counter, go to DEBOUNCE. The column does not advance.
- DEBOUNCE on tick:
  - Captured row still low: increment the counter. When the counter reaches DEBOUNCE_TICKS-1, accept the press and go to HELD.
  - Captured row high: go to SCAN and advance the column.
- Press acceptance:
  - key_held rises.
  - If key_valid = 0, or key_ready = 1 in the same cycle: key_code is loaded and key_valid = 1 from the next cycle.
  - Otherwise the press is dropped, key_lost pulses, and key_code is unchanged.
- HELD: the column stays frozen. On a tick with the captured row high, clear the counter and go to RELEASE.
- RELEASE on tick:
  - Captured row high: increment the counter. At DEBOUNCE_TICKS-1, key_held falls; go to SCAN and advance the column.
  - Captured row low: return to HELD with no new event.
- Handshake:
  - key_valid clears on any cycle with key_valid & key_ready, unless a press is accepted in that same cycle; then it stays high with the new code.
  - key_code is stable while key_valid is high.
- Column drive: col_signal is frozen in DEBOUNCE, HELD and RELEASE. Other keys are ignored until release is accepted (no rollover).
- Reset assertion mid-operation returns every register immediately to its reset value; a pending key_valid is lost.

Optional Feature:
KEYPAD_SEG7_EN
- Defined: adds output seg_data [6:0], active-low segments {g,f,e,d,c,b,a}, registered.
  - Shows the hex digit (0..F) of the last loaded key_code.
  - Codes >15 show "-" (7'b0111111).
  - Reset value is blank, 7'b1111111.
  - It updates in the cycle key_code loads.
- Undefined: the port and its logic are absent.

Decomposition:
- Package keypad_pkg holds:
  - the state enum (SCAN, DEBOUNCE, HELD, RELEASE);
  - the constants SEG_BLANK and SEG_DASH;
  - the function hex_to_seg7.
- One sub-module, keypad_debounce_cnt: tick-qualified counter with clear, terminal flag and DEBOUNCE_TICKS parameter.

Test Plan:
Bench parameters: ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE_TICKS=3.
- Reset: rst=0 then 1 with no key -> col_signal steps 1110, 1101, 1011, 0111, 1110, one step every 4 clk; key_valid = 0.
- Clean press: row_signal=1101 while col 2 is active, held 6 ticks, key_ready=1 -> exactly one key_valid pulse with key_code = 1*4+2 = 6. col_signal stays 1011 until release plus 3 high ticks.
- Bounce:
  - row1 low for 2 ticks, then high -> no key_valid; scanning resumes at col 3.
  - A 1-tick high glitch during RELEASE -> returns to HELD; no second event.
- Backpressure: key_ready=0; press key 5, release, press key 10 -> key_valid stays high with code 5 and key_lost pulses once. Raising key_ready then drops key_valid the next cycle.
- Multi-row: row_signal=1010 on col 0 -> key_code = 0 (row 0 wins).
- Mid-operation reset: rst low during HELD -> all outputs at reset values within the same cycle. With KEYPAD_SEG7_EN, seg_data = 7'b1111111.
- Optional feature: with KEYPAD_SEG7_EN, key 11 gives seg_data for "b" = 7'b0000011.
